// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: a TX FIFO fed by bus writes to TXDATA,
// a serializer FSM with a programmable baud divisor, and STATUS/DIV read-back.
module uart_tx_mmio #(
  parameter int                 XLEN        = 32,
  parameter int                 FIFO_DEPTH  = 8,
  parameter int                 DIV_W       = 16,
  parameter logic [DIV_W-1:0]   DEFAULT_DIV = 16'd868
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            req_ready,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            tx,
  output logic            irq_tx_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, busy, ovf;
  logic [DIV_W-1:0] div_reg, div_eff, div_lat, timer;
  logic [7:0]       shift;
  logic [2:0]       bitcnt;
  logic [9:0]       addr_word;
  logic             wr_txdata, push, pop, ovf_set, rd_status, bit_done;
  logic [XLEN-1:0]  rd_mux;
  logic             unused_bits;

  assign unused_bits = ^{req_addr[1:0], req_wdata[XLEN-1:DIV_W]};

  assign req_ready   = 1'b1;
  assign addr_word   = req_addr[11:2];
  assign full        = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign busy        = (state != IDLE);
  assign irq_tx_done = empty & ~busy;

  assign wr_txdata = req_valid & req_we & (addr_word == 10'd0);
  assign push      = wr_txdata & ~full;
  assign ovf_set   = wr_txdata & full;
  assign rd_status = req_valid & ~req_we & (addr_word == 10'd1);

  // A stored divisor of zero behaves as one clock per bit
  assign div_eff  = (div_reg == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : div_reg;
  assign bit_done = (timer == div_lat - 1'b1);
  // Pop either from idle or at the end of a stop bit so frames run back-to-back
  assign pop      = ~empty & ((state == IDLE) | ((state == STOP) & bit_done));

  // Read data mux, sampled into the response register on the accept edge
  always_comb begin
    rd_mux = '0;
    if (req_valid && !req_we) begin
      case (addr_word)
        10'd1:   rd_mux = {{(XLEN-4){1'b0}}, ovf, busy, empty, full};
        10'd2:   rd_mux = XLEN'(div_reg);
        default: rd_mux = '0;
      endcase
    end
  end

  // TX FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= req_wdata[7:0];
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Divisor register and sticky overflow flag (a new overflow beats a clearing read)
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= DEFAULT_DIV;
      ovf     <= 1'b0;
    end else begin
      if (req_valid && req_we && addr_word == 10'd2) div_reg <= req_wdata[DIV_W-1:0];
      if (ovf_set)        ovf <= 1'b1;
      else if (rd_status) ovf <= 1'b0;
    end
  end

  // Registered read response, valid for one cycle after an accepted read
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= req_valid & ~req_we;
      rsp_rdata <= rd_mux;
    end
  end

  // Serializer FSM: start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      timer   <= '0;
      div_lat <= {{(DIV_W-1){1'b0}}, 1'b1};
      shift   <= '0;
      bitcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (pop) begin
            shift   <= mem[rd_ptr];
            div_lat <= div_eff;
            bitcnt  <= '0;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_done) begin
            timer <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            timer <= '0;
            if (bitcnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift  <= shift >> 1;
              tx     <= shift[1];
              bitcnt <= bitcnt + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            timer <= '0;
            if (pop) begin
              shift   <= mem[rd_ptr];
              div_lat <= div_eff;
              bitcnt  <= '0;
              tx      <= 1'b0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed testbench for uart_tx_mmio: register access, frame timing,
// FIFO overflow, divisor latching, divisor zero and mid-frame reset.
module tb_uart_tx_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, rsp_valid, tx, irq_tx_done;
  logic [31:0] rsp_rdata;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  bit   logging = 1'b0;
  logic tx_log[$];

  uart_tx_mmio #(.XLEN(32), .FIFO_DEPTH(8), .DIV_W(16), .DEFAULT_DIV(16'd868)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .tx(tx), .irq_tx_done(irq_tx_done)
  );

  always #5 clk = ~clk;

  // Sample the serial line once per cycle, 1 time unit after the edge
  always @(posedge clk) begin
    #1;
    if (logging) tx_log.push_back(tx);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    @(posedge clk); #1;
    d = rsp_valid ? rsp_rdata : 32'hBAD0_0000;
    req_valid = 1'b0;
  endtask

  function automatic logic log_at(input int idx);
    if (idx < 0 || idx >= tx_log.size()) return 1'bx;
    return tx_log[idx];
  endfunction

  function automatic int first_low();
    for (int i = 0; i < tx_log.size(); i++) if (tx_log[i] == 1'b0) return i;
    return -1;
  endfunction

  // Reassemble {stop, data[7:0], start} by sampling mid-bit
  function automatic logic [9:0] frame_at(input int s, input int div);
    logic [9:0] f;
    for (int i = 0; i < 10; i++) f[i] = log_at(s + i * div + div / 2);
    return f;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int          s;
    int          zeros;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset state and register read-back
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, irq_tx_done}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("req_ready", {31'd0, req_ready}, 32'd1);
    bus_read(12'h008, d); check("rst_div", d, 32'd868);
    bus_read(12'h004, d); check("rst_status", d, 32'h2);
    bus_read(12'h000, d); check("rd_txdata", d, 32'h0);
    bus_read(12'h00C, d); check("rd_other", d, 32'h0);
    @(posedge clk); #1;
    check("rsp_idle_valid", {31'd0, rsp_valid}, 32'd0);
    check("rsp_idle_data", rsp_rdata, 32'd0);

    // 2: single byte 0xA5 at DIV=4
    bus_write(12'h008, 32'd4);
    tx_log.delete(); logging = 1'b1;
    bus_write(12'h000, 32'hA5);
    check("t2_tx_accept", {31'd0, tx}, 32'd1);
    check("t2_irq_busy", {31'd0, irq_tx_done}, 32'd0);
    @(posedge clk); #1;
    check("t2_tx_latency", {31'd0, tx}, 32'd0);
    repeat (39) @(posedge clk); #1;
    check("t2_irq_in_stop", {31'd0, irq_tx_done}, 32'd0);
    @(posedge clk); #1;
    check("t2_irq_done", {31'd0, irq_tx_done}, 32'd1);
    logging = 1'b0;
    s = first_low();
    check("t2_frame", {22'd0, frame_at(s, 4)}, {22'd0, 10'b1_10100101_0});

    // 3: overflow with ten back-to-back writes
    tx_log.delete(); logging = 1'b1;
    for (int k = 0; k < 10; k++) bus_write(12'h000, k);
    bus_read(12'h004, d); check("t3_status_ovf", d, 32'hD);
    bus_read(12'h004, d); check("t3_status_clr", d, 32'h5);
    repeat (9 * 40 + 10) @(posedge clk);
    #2 logging = 1'b0;
    s = first_low();
    for (int k = 0; k < 9; k++)
      check($sformatf("t3_frame%0d", k), {22'd0, frame_at(s + k * 40, 4)},
            {22'd0, 1'b1, k[7:0], 1'b0});
    check("t3_idle_after", {31'd0, log_at(s + 9 * 40 + 2)}, 32'd1);
    bus_read(12'h004, d); check("t3_status_end", d, 32'h2);

    // 4: divisor change mid-frame applies to the next frame only
    tx_log.delete(); logging = 1'b1;
    bus_write(12'h000, 32'h3C);
    repeat (6) @(posedge clk); #1;
    bus_write(12'h008, 32'd8);
    bus_write(12'h000, 32'hC3);
    repeat (40 + 80 + 10) @(posedge clk);
    #2 logging = 1'b0;
    s = first_low();
    check("t4_frame_div4", {22'd0, frame_at(s, 4)}, {22'd0, 10'b1_00111100_0});
    check("t4_frame_div8", {22'd0, frame_at(s + 40, 8)}, {22'd0, 10'b1_11000011_0});
    bus_read(12'h008, d); check("t4_div", d, 32'd8);

    // 5: divisor zero runs at one clock per bit
    bus_write(12'h008, 32'd0);
    bus_read(12'h008, d); check("t5_div_stored", d, 32'd0);
    tx_log.delete(); logging = 1'b1;
    bus_write(12'h000, 32'hFF);
    repeat (15) @(posedge clk);
    #2 logging = 1'b0;
    s = first_low();
    check("t5_frame", {22'd0, frame_at(s, 1)}, {22'd0, 10'b1_11111111_0});
    check("t5_before", {31'd0, log_at(s - 1)}, 32'd1);
    check("t5_after", {31'd0, log_at(s + 10)}, 32'd1);

    // 6: reset during data bit 3 discards the frame and the queued byte
    bus_write(12'h008, 32'd4);
    bus_write(12'h000, 32'h07);
    bus_write(12'h000, 32'h55);
    repeat (17) @(posedge clk); #1;
    check("t6_tx_bit3", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_tx_reset", {31'd0, tx}, 32'd1);
    check("t6_irq_reset", {31'd0, irq_tx_done}, 32'd1);
    tx_log.delete(); logging = 1'b1;
    repeat (60) @(posedge clk);
    #2 logging = 1'b0;
    zeros = 0;
    foreach (tx_log[i]) if (tx_log[i] !== 1'b1) zeros++;
    check("t6_quiet", zeros, 32'd0);
    bus_read(12'h004, d); check("t6_status", d, 32'h2);
    bus_read(12'h008, d); check("t6_div", d, 32'd868);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
